// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// display_pkg : FSM states, seven-segment patterns and decimal-limit helper
// Revision    : 1.0
// ============================================================================
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Active-low, bit order gfedcba
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_TABLE [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [63:0] dec_limit(input int digits);
    logic [63:0] lim;
    lim = 64'd1;
    for (int i = 0; i < digits; i++) begin
      lim = lim * 64'd10;
    end
    return lim - 64'd1;
  endfunction

  localparam logic [63:0] DEC_LIMIT_DEFAULT = dec_limit(4);

endpackage
`default_nettype wire

// File: rtl/seg7_encode.sv
`default_nettype none
// ============================================================================
// seg7_encode : BCD nibble to active-low seven-segment pattern
// Revision    : 1.0
// ============================================================================
module seg7_encode
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (nibble <= 4'd9) begin
      seg = SEG_TABLE[nibble];
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_hex_display.sv
`default_nettype none
// ============================================================================
// bcd_hex_display : captures a binary value, converts it to BCD by sequential
//                   double-dabble and drives blanked/overflow-aware 7-seg digits
// Revision        : 1.0
// ============================================================================
module bcd_hex_display
  import display_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     in,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  busy
);

  localparam int              CNT_W   = $clog2(DATA_W + 1);
  localparam int              BCD_W   = 4 * DIGITS;
  localparam int              HEX_W   = 7 * DIGITS;
  localparam logic [63:0]     LIMIT   = dec_limit(DIGITS);
  localparam logic [HEX_W-1:0] HEX_RST = {{(HEX_W-7){1'b1}}, SEG_TABLE[0]};

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  last_q,  last_d;
  logic [DATA_W-1:0]  sh_q,    sh_d;
  logic [BCD_W-1:0]   bcd_q,   bcd_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               ovf_q,   ovf_d;
  logic [HEX_W-1:0]   hex_q,   hex_d;

  logic [BCD_W-1:0]   bcd_adj;
  logic [HEX_W-1:0]   hex_enc;
  logic               leading;
  logic [6:0]         seg_w [DIGITS];

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
      seg7_encode u_seg (
        .nibble (bcd_q[4*g +: 4]),
        .seg    (seg_w[g])
      );
    end
  endgenerate

  // Double-dabble correction applied before each shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Scan from the most significant digit, blanking zeros until the first non-zero
  always_comb begin
    hex_enc = '1;
    leading = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      if (ovf_q) begin
        hex_enc[7*i +: 7] = SEG_DASH;
      end else if (leading && (bcd_q[4*i +: 4] == 4'd0) && (i != 0)) begin
        hex_enc[7*i +: 7] = SEG_BLANK;
      end else begin
        leading           = 1'b0;
        hex_enc[7*i +: 7] = seg_w[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    sh_d    = sh_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    hex_d   = hex_q;
    case (state_q)
      ST_IDLE: begin
        if (in != last_q) begin
          last_d  = in;
          sh_d    = in;
          bcd_d   = '0;
          cnt_d   = '0;
          ovf_d   = (64'(in) > LIMIT);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {bcd_d, sh_d} = {bcd_adj, sh_q} << 1;
        cnt_d         = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        hex_d   = hex_enc;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      last_q  <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      hex_q   <= HEX_RST;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      sh_q    <= sh_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      hex_q   <= hex_d;
    end
  end

  assign hex  = hex_q;
  assign busy = (state_q != ST_IDLE);

endmodule
`default_nettype wire
